// File: rtl/demux4_rr_dispatcher.sv
// Round-robin 1-to-4 dispatcher: holds one word at a time and offers it to the
// first enabled channel after the last one served, dropping it on timeout.
module demux4_rr_dispatcher #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       en,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic [1:0]       cur_sel,
  output logic             busy,
  output logic             drop,
  output logic [7:0]       xfer_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       deliver;
  logic       expire;

  // First set bit of mask in the circular order start, start+1, ... (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign in_ready = !rst && (state == IDLE) && (en != 4'b0000);
  assign accept   = in_valid && in_ready;
  assign deliver  = (state == SEND) && out_ready[cur_sel];
  assign expire   = (state == SEND) && !deliver && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      wait_cnt   <= 8'd0;
      out_valid  <= 4'b0000;
      out_data   <= '0;
      cur_sel    <= 2'd0;
      busy       <= 1'b0;
      drop       <= 1'b0;
      xfer_count <= 8'd0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_sel   <= pick(en, ptr);
            out_valid <= onehot(pick(en, ptr));
            out_data  <= in_data;
            wait_cnt  <= 8'd0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Delivery outranks a timeout landing in the same cycle.
          if (deliver) begin
            xfer_count <= xfer_count + 8'd1;
            ptr        <= cur_sel + 2'd1;
            out_valid  <= 4'b0000;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (expire) begin
            drop      <= 1'b1;
            ptr       <= cur_sel + 2'd1;
            out_valid <= 4'b0000;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 4'b0000;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Bench for demux4_rr_dispatcher: directed word table, reset/wrap sequences and
// random traffic, all checked cycle by cycle against a transaction-level model.
module tb_demux4_rr_dispatcher;
  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [3:0]   en;
  logic [3:0]   out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_ready;
  logic [1:0]   cur_sel;
  logic         busy;
  logic         drop;
  logic [7:0]   xfer_count;

  demux4_rr_dispatcher #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en(en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .cur_sel(cur_sel), .busy(busy), .drop(drop),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one held word, its age in SEND cycles, rotation pointer.
  bit         m_busy;
  int         m_sel, m_ptr, m_age, m_count;
  bit         m_drop;
  logic [7:0] m_data;

  typedef struct {
    logic [3:0] en;
    logic [7:0] data;
    int         ready_after;  // SEND cycle index at which out_ready[sel] rises; -1 = never
    int         exp_ch;
    bit         exp_drop;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_age = 0; m_count = 0; m_drop = 0; m_data = 8'h00;
  endtask

  // One clock: drive inputs, compare at negedge, advance model, settle past posedge.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d,
                       input logic [3:0] e, input logic [3:0] rdy);
    bit found;
    rst = r; in_valid = v; in_data = d; en = e; out_ready = rdy;
    @(negedge clk);
    chk("in_ready", in_ready, (!r && !m_busy && e != 4'b0000) ? 1 : 0);
    chk("out_valid", out_valid, m_busy ? (32'd1 << m_sel) : 32'd0);
    if (m_busy) begin
      chk("out_data", out_data, m_data);
      chk("cur_sel", cur_sel, m_sel);
    end
    chk("busy", busy, m_busy);
    chk("drop", drop, m_drop);
    chk("xfer_count", xfer_count, m_count);
    if (r) begin
      model_reset();
    end else if (!m_busy) begin
      m_drop = 0;
      if (v && e != 4'b0000) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && e[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4;
            found = 1;
          end
        end
        m_busy = 1; m_data = d; m_age = 0;
      end
    end else begin
      m_age++;
      if (rdy[m_sel]) begin
        m_count = (m_count + 1) % 256; m_ptr = (m_sel + 1) % 4; m_busy = 0; m_drop = 0;
      end else if (m_age == TO) begin
        m_drop = 1; m_ptr = (m_sel + 1) % 4; m_busy = 0;
      end else begin
        m_drop = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input vec_t t);
    int k;
    logic [3:0] rdy;
    cycle(1'b0, 1'b1, t.data, t.en, 4'b0000);
    k = 0;
    while (busy === 1'b1 && k < TO + 4) begin
      if (k == 0) chk("first_sel", out_valid, 32'd1 << t.exp_ch);
      rdy = (t.ready_after >= 0 && k >= t.ready_after) ? 4'hF : (4'hF & ~(4'b0001 << t.exp_ch));
      cycle(1'b0, 1'b0, 8'h00, t.en, rdy);
      k++;
    end
    chk("send_cycles", k, t.exp_drop ? TO : t.ready_after + 1);
    chk("drop_seen", drop, t.exp_drop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'hF, 8'hA0,  0, 0, 1'b0};
    tbl[1] = '{4'hF, 8'hA1,  0, 1, 1'b0};
    tbl[2] = '{4'hF, 8'hA2,  0, 2, 1'b0};
    tbl[3] = '{4'hF, 8'hA3,  0, 3, 1'b0};
    tbl[4] = '{4'hA, 8'hB0,  0, 1, 1'b0};
    tbl[5] = '{4'hA, 8'hB1,  0, 3, 1'b0};
    tbl[6] = '{4'h4, 8'hC0, -1, 2, 1'b1};
    tbl[7] = '{4'h4, 8'hC1,  3, 2, 1'b0};
    tbl[8] = '{4'hF, 8'hD0,  0, 3, 1'b0};
    tbl[9] = '{4'h1, 8'hD1,  2, 0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; en = 4'h0; out_ready = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(1'b1, 1'b1, 8'h11, 4'hF, 4'hF);

    for (int i = 0; i < 10; i++) begin
      run_word(tbl[i]);
      if (i == 3) chk("xfer_after_4", xfer_count, 4);
    end
    chk("xfer_after_table", xfer_count, 9);

    // Reset in the second SEND cycle.
    cycle(1'b0, 1'b1, 8'h55, 4'hF, 4'h0);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'h0);
    cycle(1'b1, 1'b1, 8'h66, 4'hF, 4'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_xfer", xfer_count, 0);
    run_word('{4'hF, 8'h77, 0, 0, 1'b0});

    // 256 deliveries wrap the counter.
    cycle(1'b1, 1'b0, 8'h00, 4'hF, 4'h0);
    for (int i = 0; i < 256; i++) run_word('{4'hF, 8'(i), 0, i % 4, 1'b0});
    chk("xfer_wrap", xfer_count, 0);

    // No enabled channel: nothing accepted.
    repeat (5) cycle(1'b0, 1'b1, 8'hAA, 4'h0, 4'hF);
    chk("en0_in_ready", in_ready, 0);
    chk("en0_out_valid", out_valid, 0);

    repeat (3000) begin
      cycle($urandom_range(0, 63) == 0, 1'($urandom), 8'($urandom),
            4'($urandom), 4'($urandom & $urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
